alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port alu_op  input  4  operation code from the ALU control decoder.
REQ-007 SHALL have port op_a  input  WIDTH  first operand.
REQ-008 SHALL have port op_b  input  WIDTH  second operand, or shift amount in its low log2(WIDTH) bits.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  WIDTH  operation result.
REQ-012 SHALL have port zero  output  1  result equals 0 and err low.
REQ-013 SHALL have port err  output  1  illegal alu_op was accepted.

Function
REQ-014 SHALL decode alu_op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 SLL, 0100 SRL, 0101 SRA; all other codes, including 1111, are illegal.
REQ-015 SHALL use FSM states IDLE, SHIFT, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 SHALL accept a request on a rising edge with in_valid=1 and in_ready=1, latching alu_op, op_a, op_b.
REQ-017 SHALL, for AND/OR/ADD/SUB/illegal, go IDLE->DONE with result registered; out_valid rises 1 cycle after accept.
REQ-018 SHALL compute ADD/SUB modulo 2^WIDTH; carry/borrow discarded, no overflow flag.
REQ-019 SHALL, for illegal codes, drive result = 0, err = 1, zero = 0.
REQ-020 SHALL, for shifts with amount n = op_b[log2(WIDTH)-1:0], shift by one bit per cycle in SHIFT, using an n-cycle down-counter.
REQ-021 SHALL go IDLE->DONE directly when n = 0 (result = op_a, latency 1); otherwise out_valid rises n+1 cycles after accept.
REQ-022 SHALL fill SLL/SRL vacated bits with 0 and SRA vacated bits with op_a[WIDTH-1].
REQ-023 SHALL hold result, zero, err, out_valid stable in DONE until a rising edge with out_ready=1, then go to IDLE.
REQ-024 SHALL NOT accept a request in the same cycle a result is consumed; minimum spacing between accepts is 2 cycles.
REQ-025 SHALL ignore in_valid, alu_op, op_a, op_b while in SHIFT or DONE.
REQ-026 SHALL drive result = 0, zero = 0, err = 0 whenever out_valid = 0.

Reset
REQ-027 SHALL, on rst_n low, immediately force state IDLE, shift counter 0, result 0, zero 0, err 0, out_valid 0, in_ready 1.
REQ-028 SHALL abort any in-flight operation on reset without producing a result; first accept possible on the first rising edge after rst_n rises.

Configuration
REQ-029 SHALL, with macro ALU_EXEC_SHIFT_EN defined, implement SLL/SRL/SRA and the SHIFT state as above.
REQ-030 SHALL, without ALU_EXEC_SHIFT_EN, omit the SHIFT state and counter and treat 0011, 0100, 0101 as illegal (REQ-019, latency 1).

Verification
REQ-031 SHALL cover: ADD op_a=0xFFFFFFFF op_b=0x00000001 -> 1 cycle later out_valid=1, result=0, zero=1, err=0.
REQ-032 SHALL cover: SUB op_a=5 op_b=7 -> result=0xFFFFFFFE, zero=0; AND 0xF0F0 with 0x0FF0 -> result=0x00F0.
REQ-033 SHALL cover: SRA op_a=0x80000000 op_b=4 -> out_valid after 5 cycles, result=0xF8000000; in_ready low for those cycles.
REQ-034 SHALL cover: alu_op=1111 -> result=0, err=1, zero=0; with ALU_EXEC_SHIFT_EN undefined, SLL likewise gives err=1.
REQ-035 SHALL cover: out_ready held low 3 cycles in DONE -> result stable; in_valid pulsed meanwhile is not accepted.
REQ-036 SHALL cover: rst_n low during SHIFT (SLL by 31) -> out_valid 0, in_ready 1 immediately, no result emitted after release.

Source files
------------

// File: rtl/alu_exec.sv
// alu_exec: single-request ALU with valid/ready handshakes and a
// serial (one bit per cycle) shifter.
//
// Parameters:
//   WIDTH      operand/result width (8, 16, 32 or 64)
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   request handshake
//   alu_op, op_a, op_b   operation code and operands
//   out_valid, out_ready result handshake
//   result, zero, err    result, zero flag, illegal-op flag
// Build option:
//   ALU_EXEC_SHIFT_EN    enables SLL/SRL/SRA and the SHIFT state;
//                        without it those codes report err.
module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err
);

`ifdef ALU_EXEC_SHIFT_EN
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DONE  = 2'd2
    } state_t;
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_result;
    logic             r_err;

    logic             w_is_and;
    logic             w_is_or;
    logic             w_is_add;
    logic             w_is_sub;
    logic [WIDTH-1:0] w_imm_res;
    logic             w_imm_err;
    logic             w_go_shift;

`ifdef ALU_EXEC_SHIFT_EN
    logic [SW-1:0]    r_cnt;
    logic [1:0]       r_sh_op;
    logic             w_is_sh;
    logic [SW-1:0]    w_shamt;
    logic [WIDTH-1:0] w_shifted;
`endif

    assign w_is_and = (alu_op == 4'b0000);
    assign w_is_or  = (alu_op == 4'b0001);
    assign w_is_add = (alu_op == 4'b0010);
    assign w_is_sub = (alu_op == 4'b0110);

`ifdef ALU_EXEC_SHIFT_EN
    assign w_is_sh  = (alu_op == 4'b0011) ||
                      (alu_op == 4'b0100) ||
                      (alu_op == 4'b0101);
    assign w_shamt  = op_b[SW-1:0];
    // A zero-length shift completes like an ordinary one-cycle op.
    assign w_go_shift = w_is_sh && (w_shamt != '0);

    // r_sh_op keeps alu_op[1:0]: 11 SLL, 00 SRL, 01 SRA.
    always_comb begin
        w_shifted = r_result;
        unique case (r_sh_op)
            2'b11:   w_shifted = {r_result[WIDTH-2:0], 1'b0};
            2'b01:   w_shifted = {r_result[WIDTH-1],
                                  r_result[WIDTH-1:1]};
            default: w_shifted = {1'b0, r_result[WIDTH-1:1]};
        endcase
    end
`else
    assign w_go_shift = 1'b0;
`endif

    // One-cycle result; shifts seed the accumulator with op_a.
    always_comb begin
        w_imm_res = '0;
        w_imm_err = 1'b0;
        unique case (1'b1)
            w_is_and: w_imm_res = op_a & op_b;
            w_is_or:  w_imm_res = op_a | op_b;
            w_is_add: w_imm_res = op_a + op_b;
            w_is_sub: w_imm_res = op_a - op_b;
`ifdef ALU_EXEC_SHIFT_EN
            w_is_sh:  w_imm_res = op_a;
`endif
            default:  w_imm_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
`ifdef ALU_EXEC_SHIFT_EN
                    w_state_nxt = w_go_shift ? SHIFT : DONE;
`else
                    w_state_nxt = DONE;
`endif
                end
            end
`ifdef ALU_EXEC_SHIFT_EN
            // Counter at zero means all n shifts are done; the
            // extra cycle here gives the n+1 latency.
            SHIFT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_err    <= 1'b0;
`ifdef ALU_EXEC_SHIFT_EN
            r_cnt    <= '0;
            r_sh_op  <= 2'b00;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_result <= w_imm_res;
                        r_err    <= w_imm_err;
`ifdef ALU_EXEC_SHIFT_EN
                        r_cnt    <= w_go_shift ? w_shamt : '0;
                        r_sh_op  <= alu_op[1:0];
`endif
                    end
                end
`ifdef ALU_EXEC_SHIFT_EN
                SHIFT: begin
                    if (r_cnt != '0) begin
                        r_result <= w_shifted;
                        r_cnt    <= r_cnt - 1'b1;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        r_result <= '0;
                        r_err    <= 1'b0;
                    end
                end
                default: begin
                    r_result <= '0;
                    r_err    <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = out_valid ? r_result : '0;
    assign err       = out_valid & r_err;
    assign zero      = out_valid & ~r_err & (r_result == '0);

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: scoreboard bench for alu_exec (WIDTH = 32).
// Define ALU_EXEC_SHIFT_EN for both files to cover the shifter.
module tb_alu_exec;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alu_op;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         err;

    int n_vec;
    int n_err;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        logic         zero;
        int           lat;
    } exp_t;

    exp_t sb[$];

    alu_exec #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] op,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t e;
        int   n;
        n     = int'(b[4:0]);
        e.res = '0;
        e.err = 1'b0;
        e.lat = 1;
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010: e.res = a + b;
            4'b0110: e.res = a - b;
`ifdef ALU_EXEC_SHIFT_EN
            4'b0011: e.res = a << n;
            4'b0100: e.res = a >> n;
            4'b0101: e.res = W'($signed(a) >>> n);
`endif
            default: e.err = 1'b1;
        endcase
`ifdef ALU_EXEC_SHIFT_EN
        if (!e.err && (op == 4'b0011 || op == 4'b0100 ||
                       op == 4'b0101) && n != 0)
            e.lat = n + 1;
`endif
        e.zero = !e.err && (e.res == '0);
        return e;
    endfunction

    task automatic run_op(input string nm,
                          input logic [3:0] op,
                          input logic [W-1:0] a,
                          input logic [W-1:0] b);
        exp_t e;
        int   cyc;
        int   rdy_hi;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s in_ready got %b want 1", nm, in_ready);
        end
        alu_op   = op;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        sb.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_op   = 4'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
        cyc    = 0;
        rdy_hi = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (out_valid === 1'b1) break;
            if (in_ready !== 1'b0) rdy_hi++;
        end
        e = sb.pop_front();
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s timeout out_valid=%b", nm, out_valid);
        end
        n_vec++;
        if (cyc !== e.lat) begin
            n_err++;
            $display("FAIL %s latency got %0d want %0d",
                     nm, cyc, e.lat);
        end
        n_vec++;
        if (result !== e.res) begin
            n_err++;
            $display("FAIL %s result got %h want %h",
                     nm, result, e.res);
        end
        n_vec++;
        if (err !== e.err || zero !== e.zero) begin
            n_err++;
            $display("FAIL %s err/zero got %b/%b want %b/%b",
                     nm, err, zero, e.err, e.zero);
        end
        n_vec++;
        if (rdy_hi !== 0) begin
            n_err++;
            $display("FAIL %s in_ready busy got %0d want 0",
                     nm, rdy_hi);
        end
    endtask

    task automatic test_reset;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_op    = 4'b0000;
        op_a      = '0;
        op_b      = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset rdy/vld got %b/%b want 1/0",
                     in_ready, out_valid);
        end
        n_vec++;
        if (result !== '0 || err !== 1'b0 || zero !== 1'b0) begin
            n_err++;
            $display("FAIL reset res/err/zero got %h/%b/%b want 0",
                     result, err, zero);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_arith;
        run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1);
        run_op("sub_neg", 4'b0110, 32'd5, 32'd7);
        run_op("and_mask", 4'b0000, 32'h0000_F0F0, 32'h0000_0FF0);
        run_op("or_bits", 4'b0001, 32'hA500_0000, 32'h0000_005A);
        run_op("sub_zero", 4'b0110, 32'h1234_5678, 32'h1234_5678);
        for (int i = 0; i < 8; i++) begin
            logic [3:0] ops [4];
            ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110};
            run_op("arith_rand", ops[i % 4], $urandom, $urandom);
        end
    endtask

    task automatic test_illegal;
        run_op("ill_1111", 4'b1111, 32'hDEAD_BEEF, 32'h1);
        run_op("ill_0111", 4'b0111, 32'h0, 32'h0);
        run_op("ill_1000", 4'b1000, 32'h5, 32'h5);
    endtask

    task automatic test_shift;
`ifdef ALU_EXEC_SHIFT_EN
        run_op("sra_4", 4'b0101, 32'h8000_0000, 32'd4);
        run_op("sll_0", 4'b0011, 32'h1234_5678, 32'd0);
        run_op("srl_31", 4'b0100, 32'h8000_0000, 32'd31);
        run_op("sll_amt_lowbits", 4'b0011, 32'h1, 32'hFFFF_FFE3);
        for (int i = 0; i < 6; i++)
            run_op("shift_rand", 4'(3 + (i % 3)), $urandom,
                   32'($urandom_range(0, 31)));
`else
        run_op("sll_off", 4'b0011, 32'h1, 32'd4);
        run_op("srl_off", 4'b0100, 32'h80, 32'd1);
        run_op("sra_off", 4'b0101, 32'h8000_0000, 32'd4);
`endif
    endtask

    task automatic test_backpressure;
        exp_t e;
        int   cyc;
        @(negedge clk);
        out_ready = 1'b0;
        alu_op    = 4'b0000;
        op_a      = 32'h0000_F0F0;
        op_b      = 32'h0000_0FF0;
        in_valid  = 1'b1;
        sb.push_back(model(4'b0000, 32'h0000_F0F0, 32'h0000_0FF0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 0;
        while (cyc < 100 && out_valid !== 1'b1) begin
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (out_valid !== 1'b1 || result !== e.res ||
                err !== e.err || zero !== e.zero) begin
                n_err++;
                $display("FAIL hold%0d got v=%b r=%h want v=1 r=%h",
                         k, out_valid, result, e.res);
            end
            n_vec++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL hold_rdy%0d got %b want 0",
                         k, in_ready);
            end
            in_valid = (k == 1);
            alu_op   = 4'b0010;
            op_a     = 32'h1;
            op_b     = 32'h1;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || result !== '0 ||
            in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL consume got v=%b r=%h rdy=%b want 0/0/1",
                     out_valid, result, in_ready);
        end
        cyc = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid !== 1'b0) cyc++;
        end
        n_vec++;
        if (cyc !== 0) begin
            n_err++;
            $display("FAIL ghost_result got %0d want 0", cyc);
        end
    endtask

    task automatic test_reset_abort;
        int seen;
        @(negedge clk);
`ifdef ALU_EXEC_SHIFT_EN
        alu_op = 4'b0011;
        op_a   = 32'h1;
        op_b   = 32'd31;
`else
        alu_op    = 4'b0010;
        op_a      = 32'h7;
        op_b      = 32'h9;
        out_ready = 1'b0;
`endif
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL abort got v=%b rdy=%b want 0/1",
                     out_valid, in_ready);
        end
        n_vec++;
        if (result !== '0 || err !== 1'b0 || zero !== 1'b0) begin
            n_err++;
            $display("FAIL abort_out got %h/%b/%b want 0",
                     result, err, zero);
        end
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        n_vec++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL abort_ghost got %0d want 0", seen);
        end
        run_op("after_reset", 4'b0010, 32'd40, 32'd2);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_arith();
        test_illegal();
        test_shift();
        test_backpressure();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
